bnn_ctrl_seq: RTL
=================

# bnn_ctrl_seq

Parametrised instruction sequencer for the BNN accelerator. It fetches 16-bit instructions from the instruction SRAM and keeps the program counter, address pointers and general registers. It drives one-cycle control words to bnn_core and address/enable pulses to the data SRAM. Compared with the first-generation controller it adds:
- a start/done handshake
- an explicit fetch/execute FSM matched to 1-cycle SRAM read latency
- stall on core back-pressure
- a hardware loop instruction and HALT
- widths set by parameter

## Interface
- PC_W, 11, instruction SRAM address width (program counter width)
- DADDR_W, 13, data SRAM address width
- REG_W, 16, width of pointer and general registers (must be ≥ DADDR_W and ≥ PC_W)
- CORE_W, 17, bnn_core control word width
- clk  in  1  single clock; all state updates on rising edge
- rst  in  1  reset, asynchronous, active-high
- start  in  1  pulse in IDLE; begins execution at address 0
- busy  out  1  high in FETCH/EXEC/STALL
- done  out  1  one-cycle pulse when HALT retires
- inst  in  16  instruction SRAM read data, valid the cycle after inst_cen=0
- inst_addr  out  PC_W  instruction SRAM address (= pc)
- inst_cen  out  1  instruction SRAM chip enable, active-low; inst_wen is tied 1 outside this block
- core_ready  in  1  bnn_core can accept a control word
- core_ctrl  out  CORE_W  control word to bnn_core; nonzero for exactly one cycle per issuing instruction
- data_addr  out  DADDR_W  data SRAM address
- data_cen  out  1  data SRAM enable, active-low
- data_wen  out  1  data SRAM write enable, active-low (0 = write)

## Operation
- FSM states:
  - IDLE: start → FETCH, with pc cleared.
  - FETCH: drive inst_addr=pc and inst_cen=0 → EXEC.
  - EXEC: decode inst. If the instruction issues to the core and core_ready=0 → STALL; otherwise retire → FETCH, or → IDLE on HALT.
  - STALL: hold until core_ready=1, then retire → FETCH.
- Registers:
  - pc (PC_W)
  - dptr (load pointer, sel 1)
  - col (column/BPU index, sel 2)
  - sptr (store pointer, sel 3)
  - r1..r4 (sel 4..7)
  - All pointer and general registers are REG_W wide; sel 0 = no register.
- Opcodes, inst[15:11]:
  - 00000 NOP: no effect.
  - 00001 LDL: sel=inst[10:8]; low byte ← inst[7:0].
  - 00010 LDH: sel=inst[10:8]; bits[15:8] ← inst[7:0]. This applies uniformly to all seven registers, including sptr.
  - 00011 LOAD: mode=inst[10:9]. 00 = weight: ctrl[7], ctrl[2:1]=col[1:0]. 01 = bias: ctrl[11]. 10 = image: ctrl[8], ctrl[2:1]=col[1:0], ctrl[16]=inst[8]. Mode 11 is treated as NOP. Data read at dptr (data_cen=0, data_wen=1). Then dptr ±1 (inst[0]=1 → +1) and col+1.
  - 00100 ADDI: sel=inst[10:8]; register += sign-extended inst[7:0], modulo 2^REG_W.
  - 00101 CMP: r1 ← (src < zero-extended inst[8:0]) ? 1 : 0. src = {pc, dptr, col, sptr}[inst[10:9]].
  - 00110 JMP: if r1≠0, pc ← pc − inst[10:0] (mod 2^PC_W); else pc+1.
  - 00111 EMPT: ctrl[0].
  - 01000 BPUE: ctrl[5], ctrl[3:1]=col[2:0], ctrl[6]=inst[10]; col+1.
  - 01001 BPUC: ctrl[9], ctrl[4:1]=col[3:0]; col+1.
  - 01010 OUT: ctrl[10], ctrl[12]=inst[10], ctrl[6]=inst[9], ctrl[13]=inst[8].
  - 01011 STORE: ctrl[14], ctrl[6]=inst[10]. Write at sptr (data_cen=0, data_wen=0). Then sptr ±1 (inst[9]=1 → +1).
  - 01100 SHIFT: ctrl[15].
  - 01101 LOOP: r4 ← r4−1. If the new r4≠0, pc ← pc − inst[10:0]; else pc+1. If r4=0 on entry it wraps to all-ones and the jump is taken.
  - 01111 HALT: done pulse → IDLE.
  - Other opcodes: treated as NOP.
- Issuing instructions are LOAD (modes 00–10), EMPT, BPUE, BPUC, OUT, STORE and SHIFT; all other opcodes never stall.
- Register updates and pc+1 happen only at retire; a stalled instruction has no side effects until then.

## Timing
- Reset values: core_ctrl=0, inst_cen=1, data_cen=1, data_wen=1, data_addr=0, inst_addr=0, busy=0, done=0; all registers 0; state IDLE.
- Minimum cost is 2 cycles per instruction (FETCH + EXEC).
- core_ctrl, data_addr, data_cen and data_wen are registered at retire and valid in the following cycle (the next FETCH) only. The data SRAM returns read data the cycle after that.
- A write to sptr/dptr followed by a STORE/LOAD uses the new value; no hazard.
- start outside IDLE is ignored.
- Asserting rst mid-program returns every output to its reset value immediately, within the same cycle.

## Structure
- Shared package bnn_pkg: opcode constants, register-select constants, core_ctrl bit indices (CTRL_EMPT=0, CTRL_WGT=7, CTRL_IMG=8, …), FSM state enum.
- One sub-module, bnn_ctrl_regfile: seven REG_W registers with byte-load, add-immediate and ±1 ports.
- Decode and FSM live in the top.

## Test plan
- Reset then start; program LDL r4,3 / NOP×2 / LOOP 1 / HALT → NOP body executes 3 times; done pulses 1 cycle after HALT retires; busy falls.
- LDL dptr,0x10; LOAD weight inc → data_addr=0x10, data_cen=0, data_wen=1, core_ctrl[7]=1 for one cycle; dptr=0x11, col=1.
- LDH sptr,0x01; LDL sptr,0x05; STORE with inst[9]=0 → write at 0x105; sptr=0x104.
- Hold core_ready=0 for 4 cycles during BPUC → core_ctrl stays 0 and col is unchanged until release; a single pulse follows.
- CMP pc<9 then JMP 3 → taken while r1=1, falls through once pc≥9; pc wraps correctly on JMP from pc=1 by 2 → 0x7FF.
- Assert rst during STALL → all outputs at reset values in the same cycle; start after rst deassertion runs from pc=0.

Source files
------------

// File: rtl/bnn_pkg.sv
// Shared definitions for the BNN instruction sequencer: opcodes, register selects,
// bnn_core control-word bit positions and the fetch/execute state encoding.
package bnn_pkg;

   localparam logic [4:0] OP_NOP   = 5'b00000;
   localparam logic [4:0] OP_LDL   = 5'b00001;
   localparam logic [4:0] OP_LDH   = 5'b00010;
   localparam logic [4:0] OP_LOAD  = 5'b00011;
   localparam logic [4:0] OP_ADDI  = 5'b00100;
   localparam logic [4:0] OP_CMP   = 5'b00101;
   localparam logic [4:0] OP_JMP   = 5'b00110;
   localparam logic [4:0] OP_EMPT  = 5'b00111;
   localparam logic [4:0] OP_BPUE  = 5'b01000;
   localparam logic [4:0] OP_BPUC  = 5'b01001;
   localparam logic [4:0] OP_OUT   = 5'b01010;
   localparam logic [4:0] OP_STORE = 5'b01011;
   localparam logic [4:0] OP_SHIFT = 5'b01100;
   localparam logic [4:0] OP_LOOP  = 5'b01101;
   localparam logic [4:0] OP_HALT  = 5'b01111;

   localparam logic [2:0] SEL_NONE = 3'd0;
   localparam logic [2:0] SEL_DPTR = 3'd1;
   localparam logic [2:0] SEL_COL  = 3'd2;
   localparam logic [2:0] SEL_SPTR = 3'd3;
   localparam logic [2:0] SEL_R1   = 3'd4;
   localparam logic [2:0] SEL_R2   = 3'd5;
   localparam logic [2:0] SEL_R3   = 3'd6;
   localparam logic [2:0] SEL_R4   = 3'd7;

   localparam logic [1:0] LD_WGT  = 2'b00;
   localparam logic [1:0] LD_BIAS = 2'b01;
   localparam logic [1:0] LD_IMG  = 2'b10;
   localparam logic [1:0] LD_NONE = 2'b11;

   localparam int CTRL_W       = 17;
   localparam int CTRL_EMPT    = 0;
   localparam int CTRL_COL_LSB = 1;
   localparam int CTRL_BPUE    = 5;
   localparam int CTRL_MODE    = 6;
   localparam int CTRL_WGT     = 7;
   localparam int CTRL_IMG     = 8;
   localparam int CTRL_BPUC    = 9;
   localparam int CTRL_OUT     = 10;
   localparam int CTRL_BIAS    = 11;
   localparam int CTRL_OUT_A   = 12;
   localparam int CTRL_OUT_B   = 13;
   localparam int CTRL_STORE   = 14;
   localparam int CTRL_SHIFT   = 15;
   localparam int CTRL_IMG_SEL = 16;

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_FETCH = 2'd1,
      ST_EXEC  = 2'd2,
      ST_STALL = 2'd3
   } seq_state_e;

   // Instructions that hand a control word to bnn_core and may therefore stall.
   function automatic logic isIssuing(input logic [4:0] op, input logic [1:0] loadMode);
      case (op)
         OP_LOAD:                                   return loadMode != LD_NONE;
         OP_EMPT, OP_BPUE, OP_BPUC, OP_OUT,
         OP_STORE, OP_SHIFT:                        return 1'b1;
         default:                                   return 1'b0;
      endcase
   endfunction

endpackage

// File: rtl/bnn_ctrl_regfile.sv
// Pointer/general register file: dptr, col, sptr, r1..r4 with byte-load,
// add-immediate, full-word write and +/-1 stepping, all committed only when en_i is high.
module bnn_ctrl_regfile
   import bnn_pkg::*;
#(
   parameter int REG_W = 16
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             en_i,
   input  logic             ldEn_i,
   input  logic             ldHigh_i,
   input  logic [2:0]       ldSel_i,
   input  logic [7:0]       ldByte_i,
   input  logic             addEn_i,
   input  logic [2:0]       addSel_i,
   input  logic [REG_W-1:0] addImm_i,
   input  logic             wrEn_i,
   input  logic [2:0]       wrSel_i,
   input  logic [REG_W-1:0] wrData_i,
   input  logic             dptrStep_i,
   input  logic             dptrUp_i,
   input  logic             colInc_i,
   input  logic             sptrStep_i,
   input  logic             sptrUp_i,
   output logic [REG_W-1:0] dptr_o,
   output logic [REG_W-1:0] col_o,
   output logic [REG_W-1:0] sptr_o,
   output logic [REG_W-1:0] r1_o,
   output logic [REG_W-1:0] r4_o
);

   logic [7:1][REG_W-1:0] regs_q, regs_d;

   function automatic logic [REG_W-1:0] stepOne(input logic [REG_W-1:0] v, input logic up);
      return up ? v + REG_W'(1) : v - REG_W'(1);
   endfunction

   // Select 0 matches no entry, so it naturally leaves every register untouched.
   always_comb begin
      regs_d = regs_q;
      for (int i = 1; i <= 7; i++) begin
         if (ldEn_i && ldSel_i == 3'(i)) begin
            if (ldHigh_i) regs_d[i][15:8] = ldByte_i;
            else          regs_d[i][7:0]  = ldByte_i;
         end
         if (addEn_i && addSel_i == 3'(i)) regs_d[i] = regs_q[i] + addImm_i;
         if (wrEn_i && wrSel_i == 3'(i))   regs_d[i] = wrData_i;
      end
      if (dptrStep_i) regs_d[SEL_DPTR] = stepOne(regs_q[SEL_DPTR], dptrUp_i);
      if (colInc_i)   regs_d[SEL_COL]  = regs_q[SEL_COL] + REG_W'(1);
      if (sptrStep_i) regs_d[SEL_SPTR] = stepOne(regs_q[SEL_SPTR], sptrUp_i);
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst)       regs_q <= '0;
      else if (en_i) regs_q <= regs_d;
   end

   assign dptr_o = regs_q[SEL_DPTR];
   assign col_o  = regs_q[SEL_COL];
   assign sptr_o = regs_q[SEL_SPTR];
   assign r1_o   = regs_q[SEL_R1];
   assign r4_o   = regs_q[SEL_R4];

endmodule

// File: rtl/bnn_ctrl_seq.sv
// BNN accelerator instruction sequencer: fetch/execute FSM over a 1-cycle-latency
// instruction SRAM, issuing one-cycle control words to bnn_core and data SRAM strobes.
module bnn_ctrl_seq
   import bnn_pkg::*;
#(
   parameter int PC_W    = 11,
   parameter int DADDR_W = 13,
   parameter int REG_W   = 16,
   parameter int CORE_W  = 17
) (
   input  logic               clk,
   input  logic               rst,
   input  logic               start,
   output logic               busy,
   output logic               done,
   input  logic [15:0]        inst,
   output logic [PC_W-1:0]    inst_addr,
   output logic               inst_cen,
   input  logic               core_ready,
   output logic [CORE_W-1:0]  core_ctrl,
   output logic [DADDR_W-1:0] data_addr,
   output logic               data_cen,
   output logic               data_wen
);

   seq_state_e state_q, state_d;
   logic [PC_W-1:0] pc_q, pcNext, pcJump;
   logic [15:0] inst_q, instCur;
   logic [4:0] opcode;
   logic [1:0] loadMode;
   logic issues, retire, isHalt;
   logic [CTRL_W-1:0] ctrlWord;
   logic memEn, memWrite;
   logic [DADDR_W-1:0] memAddr;

   logic [CORE_W-1:0] coreCtrl_q;
   logic [DADDR_W-1:0] dataAddr_q;
   logic dataCen_q, dataWen_q, done_q;

   logic ldEn, ldHigh, addEn, wrEn;
   logic dptrStep, dptrUp, colInc, sptrStep, sptrUp;
   logic [2:0] addSel;
   logic [REG_W-1:0] addImm, wrData, cmpSrc, r4Dec;
   logic [REG_W-1:0] dptr, col, sptr, r1, r4;

   // The SRAM output is only guaranteed during EXEC, so a stalled instruction is replayed from inst_q.
   assign instCur  = (state_q == ST_STALL) ? inst_q : inst;
   assign opcode   = instCur[15:11];
   assign loadMode = instCur[10:9];
   assign pcJump   = pc_q - PC_W'(instCur[10:0]);
   assign r4Dec    = r4 - REG_W'(1);

   always_comb begin
      ctrlWord = '0;
      memEn    = 1'b0;
      memWrite = 1'b0;
      memAddr  = '0;
      ldEn     = 1'b0;
      ldHigh   = 1'b0;
      addEn    = 1'b0;
      addSel   = instCur[10:8];
      addImm   = {{(REG_W-8){instCur[7]}}, instCur[7:0]};
      wrEn     = 1'b0;
      wrData   = '0;
      dptrStep = 1'b0;
      dptrUp   = instCur[0];
      colInc   = 1'b0;
      sptrStep = 1'b0;
      sptrUp   = instCur[9];
      pcNext   = pc_q + PC_W'(1);
      isHalt   = 1'b0;
      case (instCur[10:9])
         2'b00:   cmpSrc = REG_W'(pc_q);
         2'b01:   cmpSrc = dptr;
         2'b10:   cmpSrc = col;
         default: cmpSrc = sptr;
      endcase
      case (opcode)
         OP_LDL: ldEn = 1'b1;
         OP_LDH: begin
            ldEn   = 1'b1;
            ldHigh = 1'b1;
         end
         OP_LOAD: begin
            if (loadMode != LD_NONE) begin
               memEn    = 1'b1;
               memAddr  = dptr[DADDR_W-1:0];
               dptrStep = 1'b1;
               colInc   = 1'b1;
               case (loadMode)
                  LD_WGT: begin
                     ctrlWord[CTRL_WGT]          = 1'b1;
                     ctrlWord[CTRL_COL_LSB +: 2] = col[1:0];
                  end
                  LD_BIAS: ctrlWord[CTRL_BIAS] = 1'b1;
                  default: begin
                     ctrlWord[CTRL_IMG]          = 1'b1;
                     ctrlWord[CTRL_COL_LSB +: 2] = col[1:0];
                     ctrlWord[CTRL_IMG_SEL]      = instCur[8];
                  end
               endcase
            end
         end
         OP_ADDI: addEn = 1'b1;
         OP_CMP: begin
            wrEn   = 1'b1;
            wrData = (cmpSrc < REG_W'(instCur[8:0])) ? REG_W'(1) : '0;
         end
         OP_JMP: if (r1 != '0) pcNext = pcJump;
         OP_EMPT: ctrlWord[CTRL_EMPT] = 1'b1;
         OP_BPUE: begin
            ctrlWord[CTRL_BPUE]         = 1'b1;
            ctrlWord[CTRL_COL_LSB +: 3] = col[2:0];
            ctrlWord[CTRL_MODE]         = instCur[10];
            colInc                      = 1'b1;
         end
         OP_BPUC: begin
            ctrlWord[CTRL_BPUC]         = 1'b1;
            ctrlWord[CTRL_COL_LSB +: 4] = col[3:0];
            colInc                      = 1'b1;
         end
         OP_OUT: begin
            ctrlWord[CTRL_OUT]   = 1'b1;
            ctrlWord[CTRL_OUT_A] = instCur[10];
            ctrlWord[CTRL_MODE]  = instCur[9];
            ctrlWord[CTRL_OUT_B] = instCur[8];
         end
         OP_STORE: begin
            ctrlWord[CTRL_STORE] = 1'b1;
            ctrlWord[CTRL_MODE]  = instCur[10];
            memEn                = 1'b1;
            memWrite             = 1'b1;
            memAddr              = sptr[DADDR_W-1:0];
            sptrStep             = 1'b1;
         end
         OP_SHIFT: ctrlWord[CTRL_SHIFT] = 1'b1;
         OP_LOOP: begin
            addEn  = 1'b1;
            addSel = SEL_R4;
            addImm = '1;
            if (r4Dec != '0) pcNext = pcJump;
         end
         OP_HALT: isHalt = 1'b1;
         default: ;
      endcase
      issues = isIssuing(opcode, loadMode);
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) state_q <= ST_IDLE;
      else     state_q <= state_d;
   end

   always_comb begin
      state_d = state_q;
      case (state_q)
         ST_IDLE:  if (start) state_d = ST_FETCH;
         ST_FETCH: state_d = ST_EXEC;
         ST_EXEC: begin
            if (issues && !core_ready) state_d = ST_STALL;
            else if (isHalt)           state_d = ST_IDLE;
            else                       state_d = ST_FETCH;
         end
         ST_STALL: if (core_ready) state_d = ST_FETCH;
         default:  state_d = ST_IDLE;
      endcase
   end

   always_comb begin
      busy     = (state_q != ST_IDLE);
      inst_cen = (state_q != ST_FETCH);
      retire   = ((state_q == ST_EXEC) && !(issues && !core_ready)) ||
                 ((state_q == ST_STALL) && core_ready);
   end

   // Core and data-SRAM strobes are pulses registered at retire; data_addr holds between accesses.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         pc_q       <= '0;
         inst_q     <= '0;
         coreCtrl_q <= '0;
         dataAddr_q <= '0;
         dataCen_q  <= 1'b1;
         dataWen_q  <= 1'b1;
         done_q     <= 1'b0;
      end else begin
         if (state_q == ST_IDLE && start) pc_q <= '0;
         else if (retire)                 pc_q <= pcNext;
         if (state_q == ST_EXEC) inst_q <= inst;
         coreCtrl_q <= retire ? CORE_W'(ctrlWord) : '0;
         dataCen_q  <= !(retire && memEn);
         dataWen_q  <= !(retire && memEn && memWrite);
         if (retire && memEn) dataAddr_q <= memAddr;
         done_q     <= retire && isHalt;
      end
   end

   bnn_ctrl_regfile #(.REG_W(REG_W)) uRegs (
      .clk        (clk),
      .rst        (rst),
      .en_i       (retire),
      .ldEn_i     (ldEn),
      .ldHigh_i   (ldHigh),
      .ldSel_i    (instCur[10:8]),
      .ldByte_i   (instCur[7:0]),
      .addEn_i    (addEn),
      .addSel_i   (addSel),
      .addImm_i   (addImm),
      .wrEn_i     (wrEn),
      .wrSel_i    (SEL_R1),
      .wrData_i   (wrData),
      .dptrStep_i (dptrStep),
      .dptrUp_i   (dptrUp),
      .colInc_i   (colInc),
      .sptrStep_i (sptrStep),
      .sptrUp_i   (sptrUp),
      .dptr_o     (dptr),
      .col_o      (col),
      .sptr_o     (sptr),
      .r1_o       (r1),
      .r4_o       (r4)
   );

   assign inst_addr = pc_q;
   assign core_ctrl = coreCtrl_q;
   assign data_addr = dataAddr_q;
   assign data_cen  = dataCen_q;
   assign data_wen  = dataWen_q;
   assign done      = done_q;

endmodule
